// File: rtl/diff_avg_uart_tx.sv
// diff_avg_uart_tx
//   Averages blocks of 2**LOG2_N unsigned 20-bit difference words and sends
//   each average to the host as a 5-byte 8N1 UART frame:
//     SYNC_BYTE, {4'h0, avg[19:16]}, avg[15:8], avg[7:0], xor of bytes 1..3.
//   Averages that complete while a frame is in flight are counted in drop_cnt
//   and are not sent.
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        asynchronous reset, active low
//   din        difference word
//   din_valid  din qualifier
//   avg_out    most recent block average (truncated)
//   avg_valid  one-cycle pulse when avg_out updates
//   tx         UART serial line, idle high
//   busy       high while a frame is latched or being shifted
//   drop_cnt   averages not sent because busy, saturates at 255
//
// Handshake: din_valid is a pure strobe with no ready/backpressure. Every clk
// cycle with din_valid=1 transfers exactly one word; the block never stalls.
module diff_avg_uart_tx #(
    parameter int         LOG2_N       = 4,
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] din,
    input  logic        din_valid,
    output logic [19:0] avg_out,
    output logic        avg_valid,
    output logic        tx,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    localparam int             AW        = 20 + LOG2_N;
    localparam int             BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   acc_n;
    logic [LOG2_N-1:0] cnt;
    logic [BW-1:0]   baud;
    logic [2:0]      bit_idx;
    logic [2:0]      byte_idx;
    logic [39:0]     frame;      // byte k lives in frame[8k+7:8k]
    logic [7:0]      cur_byte;
    logic [7:0]      b1, b2, b3;
    logic            bit_done;
    logic            launch;

    // Accumulator is wide enough for 2**LOG2_N full-scale words.
    assign acc_n    = acc + AW'(din);
    assign bit_done = (baud == BAUD_LAST);
    assign launch   = avg_valid && (state_q == IDLE);
    assign busy     = (state_q != IDLE);

    assign b1 = {4'h0, avg_out[19:16]};
    assign b2 = avg_out[15:8];
    assign b3 = avg_out[7:0];

    // ------------------------------------------------------------------
    // Block accumulator
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            cnt       <= '0;
            avg_out   <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (din_valid) begin
                if (&cnt) begin
                    // Last word of the block: publish and start a fresh block,
                    // so a word on the very next cycle is already counted.
                    avg_out   <= acc_n[AW-1:LOG2_N];
                    avg_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= acc_n;
                    cnt <= cnt + LOG2_N'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // UART frame FSM
    // ------------------------------------------------------------------
    always_comb begin
        cur_byte = frame[7:0];
        case (byte_idx)
            3'd0:    cur_byte = frame[7:0];
            3'd1:    cur_byte = frame[15:8];
            3'd2:    cur_byte = frame[23:16];
            3'd3:    cur_byte = frame[31:24];
            default: cur_byte = frame[39:32];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // tx is decoded from registered state so reset forces it high at once.
    always_comb begin
        state_d = state_q;
        tx      = 1'b1;
        case (state_q)
            IDLE: begin
                if (launch) state_d = START;
            end
            START: begin
                tx = 1'b0;
                if (bit_done) state_d = DATA;
            end
            DATA: begin
                tx = cur_byte[bit_idx];
                if (bit_done && (bit_idx == 3'd7)) state_d = STOP;
            end
            STOP: begin
                tx = 1'b1;
                if (bit_done) state_d = (byte_idx == 3'd4) ? IDLE : START;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud     <= '0;
            bit_idx  <= 3'd0;
            byte_idx <= 3'd0;
            frame    <= '0;
            drop_cnt <= 8'd0;
        end else begin
            // Every bit (and so every state entry) gets a fresh baud count.
            if ((state_q == IDLE) || bit_done) baud <= '0;
            else                               baud <= baud + BW'(1);

            if (state_q == START)                bit_idx <= 3'd0;
            else if ((state_q == DATA) && bit_done) bit_idx <= bit_idx + 3'd1;

            if (launch) begin
                byte_idx <= 3'd0;
                frame    <= {b1 ^ b2 ^ b3, b3, b2, b1, SYNC_BYTE};
            end else if ((state_q == STOP) && bit_done && (byte_idx != 3'd4)) begin
                byte_idx <= byte_idx + 3'd1;
            end

            // Includes the final STOP cycle of a frame: busy is still high there.
            if (avg_valid && (state_q != IDLE) && (drop_cnt != 8'hFF))
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_diff_avg_uart_tx.sv
// Testbench for diff_avg_uart_tx: two instances (LOG2_N=2 with a short bit
// time, LOG2_N=4 at 434 clocks per bit), directed vector table plus
// sequences for frame overlap, back-to-back frames, drop saturation and
// reset in mid-frame.
module tb_diff_avg_uart_tx;

    localparam int CPB_A = 8;
    localparam int CPB_B = 434;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic [19:0] din_a, din_b;
    logic        dv_a, dv_b;
    logic [19:0] avg_out_a, avg_out_b;
    logic        avg_valid_a, avg_valid_b;
    logic        tx_a, tx_b, busy_a, busy_b;
    logic [7:0]  drop_cnt_a, drop_cnt_b;

    diff_avg_uart_tx #(.LOG2_N(2), .CLKS_PER_BIT(CPB_A), .SYNC_BYTE(8'hA5)) dut_a (
        .clk(clk), .rst(rst), .din(din_a), .din_valid(dv_a),
        .avg_out(avg_out_a), .avg_valid(avg_valid_a), .tx(tx_a),
        .busy(busy_a), .drop_cnt(drop_cnt_a)
    );

    diff_avg_uart_tx #(.LOG2_N(4), .CLKS_PER_BIT(CPB_B), .SYNC_BYTE(8'hA5)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .din_valid(dv_b),
        .avg_out(avg_out_b), .avg_valid(avg_valid_b), .tx(tx_b),
        .busy(busy_b), .drop_cnt(drop_cnt_b)
    );

    // ---------------- avg_valid monitors ----------------
    int          av_cnt_a = 0, av_cnt_b = 0;
    int          av_cyc_a = 0, av_cyc_b = 0;
    logic [19:0] av_val_a = '0, av_val_b = '0;

    always @(negedge clk) begin
        if (avg_valid_a === 1'b1) begin
            av_cnt_a++; av_cyc_a = cyc; av_val_a = avg_out_a;
        end
        if (avg_valid_b === 1'b1) begin
            av_cnt_b++; av_cyc_b = cyc; av_val_b = avg_out_b;
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        which;
        int          gap;
        logic [19:0] w0, w1, w2, w3;
        logic [19:0] exp_avg;
        logic [39:0] exp_frame;   // {B0,B1,B2,B3,B4}
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs [NVEC];

    task automatic set_vec(input int i, input logic which, input int gap,
                           input logic [19:0] w0, input logic [19:0] w1,
                           input logic [19:0] w2, input logic [19:0] w3,
                           input logic [19:0] exp_avg, input logic [39:0] exp_frame);
        vecs[i].which = which; vecs[i].gap = gap;
        vecs[i].w0 = w0; vecs[i].w1 = w1; vecs[i].w2 = w2; vecs[i].w3 = w3;
        vecs[i].exp_avg = exp_avg; vecs[i].exp_frame = exp_frame;
    endtask

    function automatic logic [19:0] vec_word(input int v, input int i);
        case (i % 4)
            0:       return vecs[v].w0;
            1:       return vecs[v].w1;
            2:       return vecs[v].w2;
            default: return vecs[v].w3;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    function automatic logic tx_of(input logic which);
        return which ? tx_b : tx_a;
    endfunction

    function automatic logic busy_of(input logic which);
        return which ? busy_b : busy_a;
    endfunction

    task automatic push(input logic which, input logic [19:0] w);
        if (which) begin din_b = w; dv_b = 1'b1; end
        else       begin din_a = w; dv_a = 1'b1; end
        @(negedge clk);
        if (which) begin din_b = '0; dv_b = 1'b0; end
        else       begin din_a = '0; dv_a = 1'b0; end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(2);
    endtask

    // Samples tx every cycle for a whole frame: each bit must hold its value
    // for exactly cpb cycles, start bits low, stop bits high, line idle after.
    task automatic decode(input logic which, output logic [39:0] frame,
                          output int errs, output logic busy0);
        int         cpb;
        logic [49:0] bits;
        logic       cur;
        logic       s;
        cpb   = which ? CPB_B : CPB_A;
        errs  = 0;
        bits  = '0;
        cur   = 1'b0;
        frame = '0;
        busy0 = busy_of(which);
        for (int i = 0; i < 50 * cpb; i++) begin
            if (i > 0) @(negedge clk);
            s = tx_of(which);
            if ((i % cpb) == 0) begin
                cur = s;
                bits[i / cpb] = s;
            end else if (s !== cur) begin
                errs++;
            end
        end
        for (int j = 0; j < 5; j++) begin
            if (bits[j*10] !== 1'b0)   errs++;
            if (bits[j*10+9] !== 1'b1) errs++;
            frame[39-8*j -: 8] = bits[j*10+1 +: 8];
        end
        @(negedge clk);
        if (tx_of(which) !== 1'b1) errs++;
    endtask

    // Called on the negedge where avg_valid is visible.
    task automatic check_frame(input logic which, input logic [39:0] exp_frame, input string tag);
        int          n;
        int          errs;
        logic [39:0] frame;
        logic        busy0;
        n = 0;
        while ((tx_of(which) !== 1'b0) && (n < 8)) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " launch latency"}, 40'(cyc - (which ? av_cyc_b : av_cyc_a)), 40'd1);
        decode(which, frame, errs, busy0);
        chk({tag, " frame bytes"}, frame, exp_frame);
        chk({tag, " bit timing/framing errors"}, 40'(errs), 40'd0);
        chk({tag, " busy during frame"}, 40'(busy0), 40'd1);
        chk({tag, " busy after frame"}, 40'(busy_of(which)), 40'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int c0;
        int n;
        int bad;
        string tag;

        set_vec(0, 1'b0, 1, 20'd100, 20'd200, 20'd300, 20'd401, 20'd250, 40'hA5_00_00_FA_FA);
        set_vec(1, 1'b0, 1, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 40'hA5_0F_FF_FF_0F);
        set_vec(2, 1'b0, 1, 20'd1, 20'd2, 20'd3, 20'd5, 20'd2, 40'hA5_00_00_02_02);
        set_vec(3, 1'b0, 1, 20'h12345, 20'h12345, 20'h12345, 20'h12348, 20'h12345, 40'hA5_01_23_45_67);
        set_vec(4, 1'b0, 1, 20'h80000, 20'h0, 20'h0, 20'h0, 20'h20000, 40'hA5_02_00_00_02);
        set_vec(5, 1'b0, 7, 20'd100, 20'd200, 20'd300, 20'd401, 20'd250, 40'hA5_00_00_FA_FA);
        set_vec(6, 1'b1, 1, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 40'hA5_0F_FF_FF_0F);
        set_vec(7, 1'b1, 7, 20'd100, 20'd200, 20'd300, 20'd401, 20'd250, 40'hA5_00_00_FA_FA);

        din_a = '0; dv_a = 1'b0; din_b = '0; dv_b = 1'b0;
        rst = 1'b0;
        idle(3);

        // Reset state
        chk("reset tx_a", 40'(tx_a), 40'd1);
        chk("reset busy_a", 40'(busy_a), 40'd0);
        chk("reset avg_out_a", 40'(avg_out_a), 40'd0);
        chk("reset avg_valid_a", 40'(avg_valid_a), 40'd0);
        chk("reset drop_cnt_a", 40'(drop_cnt_a), 40'd0);
        chk("reset tx_b", 40'(tx_b), 40'd1);
        chk("reset busy_b", 40'(busy_b), 40'd0);
        chk("reset drop_cnt_b", 40'(drop_cnt_b), 40'd0);
        rst = 1'b1;
        idle(2);

        // Table-driven blocks, one frame each
        for (int v = 0; v < NVEC; v++) begin
            tag = $sformatf("vec%0d", v);
            n   = vecs[v].which ? 16 : 4;
            c0  = vecs[v].which ? av_cnt_b : av_cnt_a;
            for (int i = 0; i < n; i++) begin
                if (i > 0) idle(vecs[v].gap - 1);
                push(vecs[v].which, vec_word(v, i));
            end
            check_frame(vecs[v].which, vecs[v].exp_frame, tag);
            chk({tag, " avg_valid pulses"}, 40'(vecs[v].which ? av_cnt_b : av_cnt_a), 40'(c0 + 1));
            chk({tag, " avg_out at pulse"}, 40'(vecs[v].which ? av_val_b : av_val_a), 40'(vecs[v].exp_avg));
            chk({tag, " drop_cnt"}, 40'(vecs[v].which ? drop_cnt_b : drop_cnt_a), 40'd0);
        end

        // Second average 1000 cycles into a 434-clk/bit frame is dropped
        c0 = av_cnt_b;
        for (int i = 0; i < 16; i++) push(1'b1, 20'd1000);
        fork
            check_frame(1'b1, 40'hA5_00_03_E8_EB, "overlap");
            begin
                idle(984);
                for (int i = 0; i < 16; i++) push(1'b1, 20'd2000);
            end
        join
        chk("overlap drop_cnt", 40'(drop_cnt_b), 40'd1);
        chk("overlap avg_valid pulses", 40'(av_cnt_b), 40'(c0 + 2));
        chk("overlap avg_out second", 40'(avg_out_b), 40'd2000);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (tx_b !== 1'b1) bad++;
            @(negedge clk);
        end
        chk("overlap no second frame", 40'(bad), 40'd0);

        // Average arriving on the last STOP cycle of a frame is dropped
        do_reset();
        c0 = av_cnt_a;
        for (int i = 0; i < 4; i++) push(1'b0, vec_word(0, i));
        fork
            check_frame(1'b0, 40'hA5_00_00_FA_FA, "b2b");
            begin
                idle(396);
                for (int i = 0; i < 4; i++) push(1'b0, 20'd0);
                chk("b2b busy on last stop cycle", 40'(busy_a), 40'd1);
                chk("b2b avg_valid on last stop cycle", 40'(avg_valid_a), 40'd1);
            end
        join
        chk("b2b drop_cnt", 40'(drop_cnt_a), 40'd1);
        chk("b2b avg_valid pulses", 40'(av_cnt_a), 40'(c0 + 2));
        chk("b2b avg_out", 40'(avg_out_a), 40'd0);

        // Drop counter: exact count then saturation
        do_reset();
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < 4; i++) push(1'b0, 20'd7);
            if (k == 101) chk("drops after first frame", 40'(drop_cnt_a), 40'd100);
        end
        chk("drop_cnt saturated", 40'(drop_cnt_a), 40'd255);
        idle(500);
        chk("drop_cnt holds", 40'(drop_cnt_a), 40'd255);
        chk("idle after drop burst", 40'(busy_a), 40'd0);

        // Reset asserted during DATA of B2
        do_reset();
        for (int i = 0; i < 4; i++) push(1'b0, vec_word(0, i));
        idle(180);
        chk("mid-frame busy before reset", 40'(busy_a), 40'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async reset tx", 40'(tx_a), 40'd1);
        chk("async reset busy", 40'(busy_a), 40'd0);
        chk("async reset avg_out", 40'(avg_out_a), 40'd0);
        chk("async reset drop_cnt", 40'(drop_cnt_a), 40'd0);
        @(negedge clk);
        rst = 1'b1;
        idle(3);
        for (int i = 0; i < 4; i++) push(1'b0, vec_word(3, i));
        check_frame(1'b0, 40'hA5_01_23_45_67, "post-reset");
        chk("post-reset avg_out", 40'(avg_out_a), 40'h12345);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
